// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle between the CPU side, the hiscore engine and the shared work-RAM port.
interface hs_ram_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_busy;
  logic        osd_pause;
  logic        cpu_pause;
  logic        hs_req;
  logic [15:0] hs_addr;
  logic [7:0]  hs_din;
  logic        hs_we;
  logic        hs_grant;
  logic [7:0]  hs_dout;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic        timeout_err;

  modport master (
    output cpu_addr, cpu_din, cpu_we, cpu_busy, osd_pause, hs_req,
           hs_addr, hs_din, hs_we, ram_q,
    input  cpu_pause, hs_grant, hs_dout, ram_addr, ram_dout, ram_we, timeout_err
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, cpu_busy, osd_pause, hs_req,
           hs_addr, hs_din, hs_we, ram_q,
    output cpu_pause, hs_grant, hs_dout, ram_addr, ram_dout, ram_we, timeout_err
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Shares one work-RAM port between the CPU and the hiscore engine after the CPU bus settles.
// Define HS_ARB_TIMEOUT_EN to bound the grant length with a TIMEOUT-cycle watchdog.
module hs_ram_arbiter #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic             clk_sys,
  input logic             reset_n,
  hs_ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_GRANT    = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [1:0] rst_sync_q;
  logic [7:0] hs_dout_q;
  logic       run_en_s;
  logic       in_grant_s;
  logic       pause_state_s;

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^32'(TIMEOUT);
`endif

  // Reset release synchroniser; the FSM stays in IDLE until both stages see reset gone.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_en_s = rst_sync_q[1];

  // State and counter registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 4'd0;
`ifdef HS_ARB_TIMEOUT_EN
      tmo_cnt_q    <= 16'd0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef HS_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  // Next-state logic; a dropped hs_req always wins over busy/counter events.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
`ifdef HS_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_err_d    = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.hs_req && run_en_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!bus.hs_req) begin
          state_d = ST_RELEASE;
        end else if (!bus.cpu_busy) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 4'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SETTLE: begin
        if (!bus.hs_req) begin
          state_d = ST_RELEASE;
        end else if (bus.cpu_busy) begin
          state_d = ST_DRAIN;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_GRANT;
`ifdef HS_ARB_TIMEOUT_EN
          tmo_cnt_d = 16'd0;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_GRANT: begin
        if (!bus.hs_req) begin
          state_d = ST_RELEASE;
`ifdef HS_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_RELEASE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
`else
        end else begin
          state_d = ST_GRANT;
`endif
        end
      end
      ST_RELEASE: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!bus.hs_req) begin
          state_d = ST_IDLE;
`ifdef HS_ARB_TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_grant_s    = (state_q == ST_GRANT);
  assign pause_state_s = (state_q == ST_DRAIN) || (state_q == ST_SETTLE) ||
                         (state_q == ST_GRANT) || (state_q == ST_RELEASE);

  assign bus.cpu_pause = bus.osd_pause | pause_state_s;
  assign bus.hs_grant  = in_grant_s;
  assign bus.ram_addr  = in_grant_s ? bus.hs_addr : bus.cpu_addr;
  assign bus.ram_dout  = in_grant_s ? bus.hs_din  : bus.cpu_din;
  assign bus.ram_we    = in_grant_s ? bus.hs_we   : bus.cpu_we;

  // Read-data capture for hiscore: one-cycle latency, holds outside GRANT.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_dout_q <= 8'h00;
    end else if (in_grant_s) begin
      hs_dout_q <= bus.ram_q;
    end else begin
      hs_dout_q <= hs_dout_q;
    end
  end

  assign bus.hs_dout = hs_dout_q;

`ifdef HS_ARB_TIMEOUT_EN
  assign bus.timeout_err = tmo_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter SETTLE, default 4: clk_sys cycles the CPU bus must stay idle before hiscore gets RAM (range 1..15).
REQ-002 Parameter TIMEOUT, default 65535: maximum GRANT length in clk_sys cycles; used only with HS_ARB_TIMEOUT_EN.
REQ-003 clk_sys  in  1  system clock (48 MHz); the only clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_addr  in  16  CPU work-RAM address.
REQ-006 cpu_din  in  8  CPU write data.
REQ-007 cpu_we  in  1  CPU write strobe.
REQ-008 cpu_busy  in  1  CPU memory cycle in progress.
REQ-009 osd_pause  in  1  pause request from the pause system.
REQ-010 cpu_pause  out  1  CPU halt request.
REQ-011 hs_req  in  1  hiscore RAM-access request (level).
REQ-012 hs_addr  in  16  hiscore address.
REQ-013 hs_din  in  8  hiscore write data.
REQ-014 hs_we  in  1  hiscore write strobe.
REQ-015 hs_grant  out  1  hiscore owns RAM.
REQ-016 hs_dout  out  8  registered RAM read data for hiscore.
REQ-017 ram_addr  out  16, ram_dout  out  8, ram_we  out  1  shared RAM port; ram_q  in  8  RAM read data.
REQ-018 timeout_err  out  1  sticky grant-timeout flag.

Function
REQ-019 FSM states: IDLE, DRAIN, SETTLE, GRANT, RELEASE, WAIT_LOW.
REQ-020 IDLE -> DRAIN when hs_req=1; otherwise hold.
REQ-021 DRAIN: cpu_busy=0 -> SETTLE with counter reloaded to 0; cpu_busy=1 -> hold; hs_req=0 -> RELEASE.
REQ-022 SETTLE: counter increments each cycle; cpu_busy=1 -> DRAIN; hs_req=0 -> RELEASE; counter=SETTLE-1 -> GRANT.
REQ-023 GRANT: hs_req=0 -> RELEASE.
REQ-024 RELEASE lasts exactly 1 cycle, then -> WAIT_LOW.
REQ-025 WAIT_LOW -> IDLE when hs_req=0, so a new grant requires hs_req low for at least 1 cycle.
REQ-026 The hs_req=0 exit takes priority over the cpu_busy and counter transitions in the same cycle.
REQ-027 cpu_pause = osd_pause OR (state in DRAIN, SETTLE, GRANT, RELEASE); registered state, combinational OR.
REQ-028 hs_grant = 1 only in GRANT.
REQ-029 Shared RAM port mux (combinational):
- in GRANT: ram_addr/ram_dout/ram_we = hs_addr/hs_din/hs_we;
- otherwise: cpu_addr/cpu_din/cpu_we;
- hs_we is ignored outside GRANT; cpu_we is ignored in GRANT.
REQ-030 hs_dout <= ram_q on every clk_sys edge while in GRANT; hs_dout holds otherwise (read latency 1 cycle).
REQ-031 With cpu_busy held low, hs_grant rises SETTLE+2 clk_sys edges after hs_req is first sampled high.
REQ-032 osd_pause does not affect FSM transitions; simultaneous osd_pause and hs_req arbitrate normally.

Reset
REQ-033 reset_n=0 forces immediately, from any state including GRANT, regardless of clk_sys:
- state=IDLE, counter=0;
- hs_grant=0, hs_dout=0x00, timeout_err=0;
- cpu_pause=osd_pause;
- RAM port selected to the CPU.
REQ-034 Deassertion of reset_n is synchronised internally (two-flop) before the FSM leaves IDLE.

Configuration
REQ-035 Feature macro: HS_ARB_TIMEOUT_EN.
REQ-036 With HS_ARB_TIMEOUT_EN defined:
- a 16-bit counter runs in GRANT;
- after TIMEOUT cycles in GRANT the FSM goes to RELEASE and sets timeout_err=1;
- timeout_err clears when WAIT_LOW exits to IDLE.
REQ-037 Without HS_ARB_TIMEOUT_EN: no counter, GRANT is unbounded, timeout_err is tied 0; the port list is identical in both builds.

Verification
REQ-038 Reset: reset_n=0 during GRANT with osd_pause=0 -> cpu_pause=0, hs_grant=0, ram_we=cpu_we, hs_dout=0x00 without a clock edge.
REQ-039 Grant latency: SETTLE=4, cpu_busy=0, hs_req rises -> cpu_pause=1 after 1 edge; hs_grant=1 after 6 edges.
REQ-040 Bus drain:
- cpu_busy=1 for 10 cycles -> FSM stays in DRAIN, hs_grant=0;
- cpu_busy pulsed high in the 3rd SETTLE cycle -> DRAIN, then a full 4 further SETTLE cycles before grant.
REQ-041 Access in GRANT:
- hs_addr=0x8100, hs_din=0x5A, hs_we=1, cpu_we=1 -> ram_addr=0x8100, ram_dout=0x5A, ram_we=1 in the same cycle;
- ram_q=0x33 -> hs_dout=0x33 one edge later.
REQ-042 Release: hs_req drops in GRANT -> hs_grant=0 and CPU mux next edge; cpu_pause=0 one edge later (osd_pause=0); cpu_pause stays 1 when osd_pause=1.
REQ-043 Timeout (HS_ARB_TIMEOUT_EN, TIMEOUT=100): hs_req held 300 cycles -> hs_grant drops after 100 GRANT cycles, timeout_err=1, no re-grant until hs_req low; timeout_err=0 after WAIT_LOW -> IDLE.
